// File: rtl/sim_finish_pkg.sv
// Shared types and constants for the end-of-test finish controller.
// The optional watchdog is enabled by defining SIM_FINISH_WATCHDOG_EN.
package sim_finish_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] EXIT_PASS    = 8'd0;
  localparam logic [7:0] EXIT_ERROR   = 8'd1;
  localparam logic [7:0] EXIT_TIMEOUT = 8'd2;

  localparam int DRAIN_CNT_W = 21;
  localparam int WD_CNT_W    = 32;

  // Index width for n sources, never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_finish_prio_enc.sv
// Lowest-index-first priority encoder: reports the first set request bit.
module sim_finish_prio_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning downwards lets the lowest set bit be the last (winning) write.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_finish_controller.sv
// End-of-test arbiter: classifies the first finish/error, drains, then raises a sticky finish_req.
// Optional watchdog timeout is compiled in when SIM_FINISH_WATCHDOG_EN is defined.
module sim_finish_controller
  import sim_finish_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DRAIN_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 16777216,
  parameter int SRC_IDX_W      = idxWidth(NUM_SRC)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 arm,
  input  logic [NUM_SRC-1:0]   src_finish,
  input  logic [NUM_SRC-1:0]   src_error,
  input  logic                 activity,
  output logic                 finish_req,
  output logic                 busy,
  output logic [7:0]           exit_code,
  output logic [SRC_IDX_W-1:0] first_src,
  output logic                 late_error,
  output logic [1:0]           state
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_e                 state_q;
  logic                   finishReq_q;
  logic                   busy_q;
  logic [7:0]             exitCode_q;
  logic [SRC_IDX_W-1:0]   firstSrc_q;
  logic                   lateError_q;
  logic [DRAIN_CNT_W-1:0] drainCnt_q;

  logic [SRC_IDX_W-1:0] errIdx;
  logic [SRC_IDX_W-1:0] finIdx;
  logic                 errValid;
  logic                 finValid;

  sim_finish_prio_enc #(.WIDTH(NUM_SRC), .IDX_W(SRC_IDX_W)) u_errEnc (
    .req_i   (src_error),
    .idx_o   (errIdx),
    .valid_o (errValid)
  );

  sim_finish_prio_enc #(.WIDTH(NUM_SRC), .IDX_W(SRC_IDX_W)) u_finEnc (
    .req_i   (src_finish),
    .idx_o   (finIdx),
    .valid_o (finValid)
  );

`ifdef SIM_FINISH_WATCHDOG_EN
  localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [WD_CNT_W-1:0] wdCnt_q;
`else
  logic unusedWatchdogInputs;
  assign unusedWatchdogInputs = activity ^ (TIMEOUT_CYCLES == 0);
`endif

  // Whole controller lives in one registered FSM so every output is a flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      finishReq_q <= 1'b0;
      busy_q      <= 1'b0;
      exitCode_q  <= EXIT_PASS;
      firstSrc_q  <= '0;
      lateError_q <= 1'b0;
      drainCnt_q  <= '0;
`ifdef SIM_FINISH_WATCHDOG_EN
      wdCnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
`ifdef SIM_FINISH_WATCHDOG_EN
            wdCnt_q <= '0;
`endif
          end
        end
        ARMED: begin
          if (errValid) begin
            state_q    <= DRAIN;
            exitCode_q <= EXIT_ERROR;
            firstSrc_q <= errIdx;
            drainCnt_q <= '0;
          end else if (finValid) begin
            state_q    <= DRAIN;
            exitCode_q <= EXIT_PASS;
            firstSrc_q <= finIdx;
            drainCnt_q <= '0;
          end
`ifdef SIM_FINISH_WATCHDOG_EN
          else if (wdCnt_q == WD_LAST) begin
            state_q    <= DRAIN;
            exitCode_q <= EXIT_TIMEOUT;
            firstSrc_q <= '0;
            drainCnt_q <= '0;
          end else if (activity) begin
            wdCnt_q <= '0;
          end else if (wdCnt_q != '1) begin
            wdCnt_q <= wdCnt_q + WD_CNT_W'(1);
          end
`endif
        end
        DRAIN: begin
          // Late errors only upgrade a pass; a timeout verdict is kept.
          if (|src_error) begin
            lateError_q <= 1'b1;
            if (exitCode_q == EXIT_PASS) begin
              exitCode_q <= EXIT_ERROR;
            end
          end
          if (drainCnt_q >= DRAIN_LAST) begin
            state_q     <= DONE;
            finishReq_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            drainCnt_q <= drainCnt_q + DRAIN_CNT_W'(1);
          end
        end
        default: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  assign finish_req = finishReq_q;
  assign busy       = busy_q;
  assign exit_code  = exitCode_q;
  assign first_src  = firstSrc_q;
  assign late_error = lateError_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sim_finish_controller.sv
// Self-checking bench for sim_finish_controller: vector table, corner sequences and a randomized run against a reference model.
module tb_sim_finish_controller;

  localparam int NSRC    = 4;
  localparam int DRAIN   = 8;
  localparam int TIMEOUT = 50;
`ifdef SIM_FINISH_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       arm;
  logic [3:0] src_finish;
  logic [3:0] src_error;
  logic       activity;
  logic       finish_req;
  logic       busy;
  logic [7:0] exit_code;
  logic [1:0] first_src;
  logic       late_error;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  sim_finish_controller #(
    .NUM_SRC(NSRC), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm),
    .src_finish(src_finish), .src_error(src_error), .activity(activity),
    .finish_req(finish_req), .busy(busy), .exit_code(exit_code),
    .first_src(first_src), .late_error(late_error), .state(state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       arm;
    logic [3:0] fin;
    logic [3:0] err;
    logic [1:0] st;
    logic       busy;
    logic       fr;
    logic [7:0] ex;
    logic [1:0] fs;
    logic       late;
  } vec_t;

  vec_t vecs[13];

  // Reference model: a phase number plus a countdown of remaining drain edges.
  int         mPhase;
  int         mLeft;
  int         mIdle;
  logic [7:0] mExit;
  int         mFirst;
  bit         mLate;

  function automatic vec_t mk(logic a, logic [3:0] f, logic [3:0] e, logic [1:0] st,
                              logic b, logic fr, logic [7:0] ex, logic [1:0] fs, logic l);
    vec_t v;
    v.arm = a; v.fin = f; v.err = e; v.st = st; v.busy = b;
    v.fr = fr; v.ex = ex; v.fs = fs; v.late = l;
    return v;
  endfunction

  function automatic int lowest(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mPhase = 0; mLeft = 0; mIdle = 0; mExit = 8'd0; mFirst = 0; mLate = 1'b0;
  endtask

  task automatic modelEdge(input bit a, input logic [3:0] f, input logic [3:0] e, input bit act);
    if (mPhase == 0) begin
      if (a) begin mPhase = 1; mIdle = 0; end
    end else if (mPhase == 1) begin
      if (e != 0) begin
        mPhase = 2; mExit = 8'd1; mFirst = lowest(e); mLeft = DRAIN;
      end else if (f != 0) begin
        mPhase = 2; mExit = 8'd0; mFirst = lowest(f); mLeft = DRAIN;
      end else if (WD_EN && mIdle == TIMEOUT - 1) begin
        mPhase = 2; mExit = 8'd2; mFirst = 0; mLeft = DRAIN;
      end else begin
        mIdle = act ? 0 : mIdle + 1;
      end
    end else if (mPhase == 2) begin
      if (e != 0) begin
        mLate = 1'b1;
        if (mExit == 8'd0) mExit = 8'd1;
      end
      mLeft = mLeft - 1;
      if (mLeft == 0) mPhase = 3;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input bit a, input logic [3:0] f, input logic [3:0] e, input bit act);
    arm = a; src_finish = f; src_error = e; activity = act;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareAll(input string tag, input logic [1:0] st, input logic b, input logic fr,
                            input logic [7:0] ex, input logic [1:0] fs, input logic l);
    checkOutput({tag, " state"}, 32'(state), 32'(st));
    checkOutput({tag, " busy"}, 32'(busy), 32'(b));
    checkOutput({tag, " finish_req"}, 32'(finish_req), 32'(fr));
    checkOutput({tag, " exit_code"}, 32'(exit_code), 32'(ex));
    checkOutput({tag, " first_src"}, 32'(first_src), 32'(fs));
    checkOutput({tag, " late_error"}, 32'(late_error), 32'(l));
  endtask

  task automatic doReset();
    arm = 0; src_finish = 0; src_error = 0; activity = 0;
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    modelReset();
  endtask

  // Arm, trigger on finish bit 2 ten cycles later and measure the latency to finish_req.
  task automatic basicPass(input string tag);
    int n;
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    for (int i = 1; i < 10; i++) applyStimulus(1, 4'b0000, 4'b0000, 0);
    applyStimulus(1, 4'b0100, 4'b0000, 0);
    n = 1;
    arm = 0; src_finish = 0;
    while (finish_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(DRAIN + 1));
    compareAll(tag, 2'd3, 1'b0, 1'b1, 8'd0, 2'd2, 1'b0);
  endtask

  initial begin
    int n;
    vecs[0]  = mk(0, 4'hF, 4'hF, 2'd0, 0, 0, 8'd0, 2'd0, 0);
    vecs[1]  = mk(0, 4'h0, 4'h4, 2'd0, 0, 0, 8'd0, 2'd0, 0);
    vecs[2]  = mk(1, 4'h0, 4'h0, 2'd1, 1, 0, 8'd0, 2'd0, 0);
    vecs[3]  = mk(0, 4'h1, 4'hA, 2'd2, 1, 0, 8'd1, 2'd1, 0);
    vecs[4]  = mk(0, 4'h8, 4'h0, 2'd2, 1, 0, 8'd1, 2'd1, 0);
    vecs[5]  = mk(0, 4'h0, 4'h8, 2'd2, 1, 0, 8'd1, 2'd1, 1);
    for (int i = 6; i <= 10; i++) vecs[i] = mk(0, 4'h0, 4'h0, 2'd2, 1, 0, 8'd1, 2'd1, 1);
    vecs[11] = mk(0, 4'h0, 4'h0, 2'd3, 0, 1, 8'd1, 2'd1, 1);
    vecs[12] = mk(1, 4'hF, 4'hF, 2'd3, 0, 1, 8'd1, 2'd1, 1);

    doReset();
    compareAll("reset", 2'd0, 0, 0, 8'd0, 2'd0, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].arm, vecs[i].fin, vecs[i].err, 1'b0);
      compareAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].busy, vecs[i].fr,
                 vecs[i].ex, vecs[i].fs, vecs[i].late);
    end

    doReset();
    basicPass("basic");

    // Late error three cycles into drain upgrades a pass without moving finish_req.
    doReset();
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0001, 4'b0000, 0);
    n = 1;
    for (int i = 0; i < 3; i++) begin applyStimulus(0, 4'b0000, 4'b0000, 0); n++; end
    applyStimulus(0, 4'b0000, 4'b1000, 0);
    n++;
    src_error = 0;
    while (finish_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("late latency", 32'(n), 32'(DRAIN + 1));
    compareAll("late", 2'd3, 0, 1, 8'd1, 2'd0, 1);

    // Asynchronous reset in the middle of drain clears everything before the next edge.
    doReset();
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0010, 4'b0100, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    compareAll("async reset", 2'd0, 0, 0, 8'd0, 2'd0, 0);
    tick();
    sys_rst_n = 1'b1;
    basicPass("rearm");

`ifdef SIM_FINISH_WATCHDOG_EN
    doReset();
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 28; i++) applyStimulus(0, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 1);
    activity = 0;
    n = 0;
    while (state !== 2'd2 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("wd timeout cycles", 32'(n), 32'(TIMEOUT));
    compareAll("wd timeout", 2'd2, 1, 0, 8'd2, 2'd0, 0);

    doReset();
    applyStimulus(1, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 4'b0000, 4'b0000, 0);
    applyStimulus(0, 4'b0001, 4'b0000, 0);
    compareAll("wd vs finish", 2'd2, 1, 0, 8'd0, 2'd0, 0);
`endif

    // Randomized episodes compared every cycle with the reference model.
    for (int ep = 0; ep < 25; ep++) begin
      doReset();
      for (int c = 0; c < 90; c++) begin
        logic       a;
        logic [3:0] f;
        logic [3:0] e;
        logic       act;
        a   = ($urandom_range(0, 5) == 0);
        f   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
        e   = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'h0;
        act = ($urandom_range(0, 29) == 0);
        modelEdge(a, f, e, act);
        applyStimulus(a, f, e, act);
        compareAll($sformatf("rand ep%0d c%0d", ep, c), 2'(mPhase),
                   (mPhase == 1 || mPhase == 2), (mPhase == 3), mExit, 2'(mFirst), mLate);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sim_finish_controller.md
Name: sim_finish_controller

Overview:
Parametrised end-of-test arbiter for the DDR5 tester simulation harnesses. It collects finish and error indications from NUM_SRC sources (for example the SoC finish signal, the UART checker and the DRAM model). It classifies the result and waits a drain interval so that UART and log output can flush. It then raises a single sticky finish_req, which the top-level sim wrapper turns into $finish. Unlike a bare finish pass-through, it provides multi-source arbitration, pass/fail exit codes and draining.

Parameters:
- NUM_SRC, 4: number of finish/error source channels (1..32).
- DRAIN_CYCLES, 1024: cycles held in DRAIN before finish_req rises (1..2^20).
- TIMEOUT_CYCLES, 16777216: watchdog limit in cycles without activity (used only with the optional feature).
- SRC_IDX_W, $clog2(NUM_SRC) with a minimum of 1: width of the source index.

Ports:
- sys_clk, input, 1: single clock.
- sys_rst_n, input, 1: reset, asynchronous, active-low.
- arm, input, 1: level; the controller leaves IDLE when it is high.
- src_finish, input, NUM_SRC: per-source finish request, level or pulse.
- src_error, input, NUM_SRC: per-source error indication, level or pulse.
- activity, input, 1: progress pulse (for example a UART byte) that restarts the watchdog.
- finish_req, output, 1: sticky; the wrapper issues $finish when it is 1.
- busy, output, 1: high in ARMED or DRAIN.
- exit_code, output, 8: 0 = pass, 1 = error, 2 = timeout.
- first_src, output, SRC_IDX_W: source that triggered the end of test.
- late_error, output, 1: an error arrived during DRAIN.
- state, output, 2: IDLE=0, ARMED=1, DRAIN=2, DONE=3.

Behaviour:
- Reset values: state IDLE; finish_req, busy and late_error 0; exit_code 0; first_src 0; all counters 0.
- All outputs are registered.
- IDLE:
  - Sources are ignored.
  - arm=1 moves to ARMED on the next edge.
- ARMED:
  - trig = |src_error | |src_finish.
  - On trig, move to DRAIN in the next cycle.
  - If any src_error bit is set: exit_code=1 and first_src = lowest-index set bit of src_error. Error has priority over finish in the same cycle.
  - Otherwise: exit_code=0 and first_src = lowest-index set bit of src_finish.
  - Deasserting arm in ARMED has no effect.
- DRAIN:
  - drain_cnt counts from 0; at DRAIN_CYCLES-1 the state moves to DONE.
  - Time from trigger to finish_req = DRAIN_CYCLES+1 cycles.
  - A src_error during DRAIN sets late_error=1. If exit_code==0 it becomes 1; first_src is not changed.
  - Further finishes are ignored.
- DONE:
  - finish_req=1 and busy=0.
  - All outputs hold until reset; arm and sources are ignored.
- Reset mid-operation: asynchronous return to IDLE; all counters and status are cleared immediately.
- Counters saturate and never wrap.
- Sources are assumed to be synchronous to sys_clk; no synchroniser is included.

Optional Feature:
- Macro: SIM_FINISH_WATCHDOG_EN.
- When defined:
  - A 32-bit wd_cnt increments in ARMED and is cleared by activity or by entry to ARMED.
  - When wd_cnt==TIMEOUT_CYCLES-1 and no trig occurs that cycle: move to DRAIN with exit_code=2 and first_src=0.
  - trig in the same cycle wins over the timeout.
  - Errors during DRAIN set late_error but do not override code 2.
- When undefined: no watchdog logic; activity is ignored; exit_code never equals 2.

Decomposition:
- Package sim_finish_pkg:
  - state_e enum (IDLE, ARMED, DRAIN, DONE).
  - Exit code constants EXIT_PASS=8'd0, EXIT_ERROR=8'd1, EXIT_TIMEOUT=8'd2.
- Sub-module sim_finish_prio_enc: parametrised lowest-index-first priority encoder (NUM_SRC in, index plus valid out). It is instantiated twice, once for errors and once for finishes.

Test Plan:
- Basic pass:
  - Stimulus: arm=1, then src_finish=4'b0100 pulse at cycle 10, DRAIN_CYCLES=8.
  - Required: finish_req=1 at cycle 19, exit_code=0, first_src=2, late_error=0.
- Error priority, simultaneous sources:
  - Stimulus: src_finish=4'b0001 and src_error=4'b1010 in the same cycle.
  - Required: exit_code=1, first_src=1.
- Late error:
  - Stimulus: finish on source 0, then src_error[3] pulse 3 cycles into DRAIN.
  - Required: late_error=1, exit_code=1, first_src=0; finish_req timing unchanged.
- Pre-arm and post-done immunity:
  - Stimulus: sources pulsed in IDLE, and again in DONE.
  - Required: state stays IDLE in the first case; all outputs are unchanged in the second.
- Reset mid-DRAIN:
  - Stimulus: sys_rst_n=0 asynchronously mid-DRAIN.
  - Required: state=0, finish_req=0, exit_code=0 before the next edge; re-arm then behaves as in the basic pass case.
- Watchdog (SIM_FINISH_WATCHDOG_EN defined, TIMEOUT_CYCLES=50):
  - Stimulus: activity pulse at cycle 30, no sources.
  - Required: DRAIN entered after 50 idle cycles, exit_code=2; a finish on the same cycle as the timeout gives exit_code=0.
